// File: rtl/tex_rom_arbiter_if.sv
// Request/response and pROM pin bundle for the texture ROM arbiter.
// slave = arbiter side, master = renderer/ROM environment side.
interface tex_rom_arbiter_if #(
    parameter int U_W    = 4,
    parameter int V_W    = 4,
    parameter int DATA_W = 24
);
    localparam int AD_W = U_W + V_W;

    logic              req0_valid;
    logic              req0_ready;
    logic [U_W-1:0]    req0_u;
    logic [V_W-1:0]    req0_v;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp0_transp;

    logic              req1_valid;
    logic              req1_ready;
    logic [U_W-1:0]    req1_u;
    logic [V_W-1:0]    req1_v;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_data;
    logic              rsp1_transp;

    logic              rom_ce;
    logic              rom_oce;
    logic              rom_reset;
    logic [AD_W-1:0]   rom_ad;
    logic [DATA_W-1:0] rom_dout;

    modport slave (
        input  req0_valid, req0_u, req0_v,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_transp,
        input  req1_valid, req1_u, req1_v,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_transp,
        output rom_ce, rom_oce, rom_reset, rom_ad,
        input  rom_dout
    );

    modport master (
        output req0_valid, req0_u, req0_v,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_transp,
        output req1_valid, req1_u, req1_v,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_transp,
        input  rom_ce, rom_oce, rom_reset, rom_ad,
        output rom_dout
    );
endinterface

// File: rtl/tex_rom_arbiter.sv
// Two-port arbiter in front of the single-port 256x24 texture pROM.
// Port 0 (display) has priority; port 1 (draw engine) has bounded wait.
module tex_rom_arbiter #(
    parameter int          U_W         = 4,
    parameter int          V_W         = 4,
    parameter int          DATA_W      = 24,
    parameter int          MAX_WAIT    = 7,
    parameter int          INIT_CYCLES = 2,
    parameter logic [23:0] TRANSP_KEY  = 24'h000000
) (
    input  logic              clk,
    input  logic              reset,
    tex_rom_arbiter_if.slave  bus,
    output logic              busy
);
    localparam int AD_W = U_W + V_W;
    localparam int IC_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WC_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [IC_W-1:0]   init_cnt_q, init_cnt_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_port_q, s1_port_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
    logic              rsp0_transp_q, rsp0_transp_d;
    logic              rsp1_transp_q, rsp1_transp_d;

    logic              run_s;
    logic              grant0_s;
    logic              grant1_s;
    logic [AD_W-1:0]   rom_ad_s;

    function automatic logic is_transp(input logic [DATA_W-1:0] texel);
        return (texel == DATA_W'(TRANSP_KEY));
    endfunction

    // State, counter and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_port_q     <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_data_q   <= '0;
            rsp1_data_q   <= '0;
            rsp0_transp_q <= 1'b0;
            rsp1_transp_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            s1_valid_q    <= s1_valid_d;
            s1_port_q     <= s1_port_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_data_q   <= rsp0_data_d;
            rsp1_data_q   <= rsp1_data_d;
            rsp0_transp_q <= rsp0_transp_d;
            rsp1_transp_q <= rsp1_transp_d;
        end
    end

    // Next state: hold the ROM in reset for INIT_CYCLES, then run forever
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == IC_W'(INIT_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Arbitration, ROM drive and wait counter
    always_comb begin
        run_s    = (state_q == ST_RUN);
        grant1_s = 1'b0;
        grant0_s = 1'b0;
        rom_ad_s = '0;
        // Port 1 takes the slot when port 0 is idle or port 1 has waited its maximum
        if (run_s && bus.req1_valid &&
            (!bus.req0_valid || (wait_cnt_q == WC_W'(MAX_WAIT)))) begin
            grant1_s = 1'b1;
        end else if (run_s && bus.req0_valid) begin
            grant0_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
        end

        if (grant1_s) begin
            rom_ad_s = {bus.req1_v, bus.req1_u};
        end else if (grant0_s) begin
            rom_ad_s = {bus.req0_v, bus.req0_u};
        end else begin
            rom_ad_s = '0;
        end

        if (!run_s || !bus.req1_valid || grant1_s) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Tag in-flight reads and route the ROM data back to the issuing port
    always_comb begin
        s1_valid_d    = grant0_s | grant1_s;
        s1_port_d     = grant1_s;
        rsp0_valid_d  = s1_valid_q & ~s1_port_q;
        rsp1_valid_d  = s1_valid_q & s1_port_q;
        rsp0_data_d   = rsp0_data_q;
        rsp0_transp_d = rsp0_transp_q;
        rsp1_data_d   = rsp1_data_q;
        rsp1_transp_d = rsp1_transp_q;
        if (rsp0_valid_d) begin
            rsp0_data_d   = bus.rom_dout;
            rsp0_transp_d = is_transp(bus.rom_dout);
        end else begin
            rsp0_transp_d = rsp0_transp_q;
        end
        if (rsp1_valid_d) begin
            rsp1_data_d   = bus.rom_dout;
            rsp1_transp_d = is_transp(bus.rom_dout);
        end else begin
            rsp1_transp_d = rsp1_transp_q;
        end
    end

    assign bus.req0_ready  = grant0_s;
    assign bus.req1_ready  = grant1_s;
    assign bus.rom_ce      = grant0_s | grant1_s;
    assign bus.rom_oce     = run_s;
    assign bus.rom_reset   = ~run_s;
    assign bus.rom_ad      = rom_ad_s;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp0_data   = rsp0_data_q;
    assign bus.rsp0_transp = rsp0_transp_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp1_data   = rsp1_data_q;
    assign bus.rsp1_transp = rsp1_transp_q;
    assign busy = ~run_s | s1_valid_q | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_tex_rom_arbiter.sv
// Scoreboard bench for tex_rom_arbiter: stimulus pushes expected texels at
// accept time, a negedge monitor pops and compares every response pulse.
module tb_tex_rom_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [23:0] rom_q = 24'h0;

    typedef struct {
        bit          port;
        logic [23:0] data;
        bit          transp;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    tex_rom_arbiter_if bus ();

    tex_rom_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench ROM: 8'h10 stores the transparent key, everything else A5_00_ad
    function automatic logic [23:0] rom_fn(input logic [7:0] ad);
        if (ad == 8'h10) return 24'h000000;
        return {8'hA5, 8'h00, ad};
    endfunction

    always @(posedge clk) if (bus.rom_ce) rom_q <= rom_fn(bus.rom_ad);
    assign bus.rom_dout = rom_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit port, input logic [23:0] data);
        exp_t e;
        e.port = port; e.data = data; e.transp = (data == 24'h0); e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (bus.rsp0_valid && bus.rsp1_valid) begin
            checks++; errors++;
            $display("FAIL dual_rsp: both rsp valid at cycle %0d", cyc);
        end else if (bus.rsp0_valid || bus.rsp1_valid) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: rsp0=%0b rsp1=%0b with empty scoreboard at cycle %0d",
                         bus.rsp0_valid, bus.rsp1_valid, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_port", {31'h0, bus.rsp1_valid}, {31'h0, mon_e.port});
                check("rsp_data", bus.rsp1_valid ? bus.rsp1_data : bus.rsp0_data, mon_e.data);
                check("rsp_transp", bus.rsp1_valid ? bus.rsp1_transp : bus.rsp0_transp, mon_e.transp);
                check("rsp_latency", cyc - mon_e.cyc, 2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request on one port, held until accepted
    task automatic issue(input bit port, input logic [3:0] u, input logic [3:0] v,
                         input logic [23:0] exp_data, input bit track);
        bit got = 1'b0;
        if (port) begin bus.req1_valid = 1'b1; bus.req1_u = u; bus.req1_v = v; end
        else      begin bus.req0_valid = 1'b1; bus.req0_u = u; bus.req0_v = v; end
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (port ? bus.req1_ready : bus.req0_ready) begin
                got = 1'b1;
                check("accept_ad", bus.rom_ad, {v, u});
                check("accept_ce", bus.rom_ce, 1);
                check("other_ready", port ? bus.req0_ready : bus.req1_ready, 0);
                if (track) push(port, exp_data);
            end
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: port %0d never ready", port);
        end
    endtask

    // Both ports valid every cycle: port 1 expected on every 8th cycle
    task automatic both_loop(input int n);
        logic [3:0] u0 = 4'h0;
        logic [3:0] u1 = 4'h0;
        bus.req0_valid = 1'b1; bus.req0_u = u0; bus.req0_v = 4'h4;
        bus.req1_valid = 1'b1; bus.req1_u = u1; bus.req1_v = 4'h5;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("grant1_pattern", bus.req1_ready, (i % 8 == 7) ? 1 : 0);
            check("grant0_pattern", bus.req0_ready, (i % 8 == 7) ? 0 : 1);
            if (bus.req0_ready) push(1'b0, rom_fn({4'h4, u0}));
            if (bus.req1_ready) push(1'b1, rom_fn({4'h5, u1}));
            step();
            if (bus.req0_ready) begin u0 = u0 + 4'h1; bus.req0_u = u0; end
            if (bus.req1_ready) begin u1 = u1 + 4'h1; bus.req1_u = u1; end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy) done = 1'b1;
            step();
        end
        check("drain_empty", sb_q.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_u = 4'h0; bus.req0_v = 4'h0;
        bus.req1_valid = 1'b0; bus.req1_u = 4'h0; bus.req1_v = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rom_reset", bus.rom_reset, 1);
        check("rst_rom_ce", bus.rom_ce, 0);
        check("rst_rom_ad", bus.rom_ad, 0);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_rsp0", {bus.rsp0_valid, bus.rsp0_transp, bus.rsp0_data}, 0);
        check("rst_rsp1", {bus.rsp1_valid, bus.rsp1_transp, bus.rsp1_data}, 0);
        step();
        reset = 1'b0;

        // 1: INIT lasts exactly two cycles after reset release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("init_rom_reset", bus.rom_reset, (i < 2) ? 1 : 0);
            check("init_busy", busy, (i < 2) ? 1 : 0);
            check("init_ready", {bus.req0_ready, bus.req1_ready}, 0);
            step();
        end

        // 2: single port 0 read
        issue(1'b0, 4'd3, 4'd2, 24'hA50023, 1'b1);
        drain();

        // 3: back-to-back port 1 reads including the corner address
        issue(1'b1, 4'd0, 4'd0, 24'hA50000, 1'b1);
        issue(1'b1, 4'd15, 4'd15, 24'hA500FF, 1'b1);
        issue(1'b1, 4'd1, 4'd0, 24'hA50001, 1'b1);
        drain();

        // 4: contention, 7:1 grant pattern
        both_loop(16);
        drain();

        // 5: transparent texel
        issue(1'b1, 4'd0, 4'd1, 24'h000000, 1'b1);
        drain();

        // 6: reset one cycle after an accept drops the read and repeats INIT
        issue(1'b0, 4'd7, 4'd7, 24'hA50077, 1'b0);
        reset = 1'b1;
        step();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp0", bus.rsp0_valid, 0);
        check("mid_rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
        check("mid_rst_rom_reset", bus.rom_reset, 1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reinit_ready", {bus.req0_ready, bus.req1_ready}, 0);
            check("reinit_rom_reset", bus.rom_reset, 1);
            step();
        end
        both_loop(8);
        issue(1'b0, 4'd9, 4'd3, 24'hA50039, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
